// File: rtl/led_blinker_multi.sv
// ---------------------------------------------------------------------------
// led_blinker_multi
//
// Multi-channel LED driver. A shared prescaler produces a one-cycle tick every
// TICK_DIV clocks. Each channel is independently OFF, ON, BLINK (toggle every
// max(HALF,1) ticks) or BURST (BURST_N flashes followed by a dark gap of
// 2*BURST_N halves).
//
// Ports:
//   CLOCK_50  in   system clock
//   RESET_N   in   asynchronous active-low reset
//   EN        in   global run enable; 0 freezes the prescaler and all timing
//   MODE      in   [2i+1:2i] per channel: 00 OFF, 01 ON, 10 BLINK, 11 BURST
//   HALF      in   [HALF_W*i +: HALF_W] per channel half-period in ticks (0 acts as 1)
//   LED       out  registered LED drive, 1 = lit
//   TICK      out  registered one-cycle prescaler tick
//
// No handshakes: all inputs are level-sampled every clock, all outputs are
// registered and valid every cycle.
// ---------------------------------------------------------------------------
module led_blinker_multi #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 50000,
  parameter int HALF_W   = 10,
  parameter int BURST_N  = 3
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic                       EN,
  input  logic [2*CHANNELS-1:0]      MODE,
  input  logic [HALF_W*CHANNELS-1:0] HALF,
  output logic [CHANNELS-1:0]        LED,
  output logic                       TICK
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int HC_W  = $clog2(4 * BURST_N);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [HC_W-1:0]  HC_LAST    = HC_W'(4 * BURST_N - 1);
  localparam logic [HC_W-1:0]  HC_ON_END  = HC_W'(2 * BURST_N);

  // -------------------------------------------------------------------------
  // Shared prescaler. Free-running; channel mode changes never restart it.
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] pre;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre  <= '0;
      TICK <= 1'b0;
    end else if (EN) begin
      if (pre == PRE_LAST) begin
        pre  <= '0;
        TICK <= 1'b1;
      end else begin
        pre  <= pre + PRE_W'(1);
        TICK <= 1'b0;
      end
    end else begin
      TICK <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel state: registered mode, tick counter within a half, and the
  // half counter used by BURST.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]        mode_in;
    logic [HALF_W-1:0] half_in;
    logic [HALF_W-1:0] half_last;
    logic [1:0]        mode_q;
    logic [HALF_W-1:0] cnt;
    logic [HC_W-1:0]   hc;
    logic [HC_W-1:0]   hc_next;
    logic              burst_led;
    logic              at_end;
    logic              led_q;

    assign mode_in   = MODE[2*i +: 2];
    assign half_in   = HALF[HALF_W*i +: HALF_W];
    // Last count value of a half: max(HALF,1)-1.
    assign half_last = (half_in == '0) ? '0 : half_in - HALF_W'(1);
    // ">=" rather than "==" so a shrunk HALF ends the half at the next tick.
    assign at_end    = (cnt >= half_last);
    assign hc_next   = (hc == HC_LAST) ? '0 : hc + HC_W'(1);
    // Lit on even halves within the first 2*BURST_N halves of the cycle.
    assign burst_led = (hc_next < HC_ON_END) & ~hc_next[0];
    assign LED[i]    = led_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        mode_q <= MODE_OFF;
        cnt    <= '0;
        hc     <= '0;
        led_q  <= 1'b0;
      end else if (mode_in != mode_q) begin
        // Mode entry beats a coincident tick and is independent of EN.
        mode_q <= mode_in;
        cnt    <= '0;
        hc     <= '0;
        led_q  <= (mode_in != MODE_OFF);
      end else begin
        case (mode_q)
          MODE_OFF: begin
            cnt   <= '0;
            hc    <= '0;
            led_q <= 1'b0;
          end
          MODE_ON: begin
            cnt   <= '0;
            hc    <= '0;
            led_q <= 1'b1;
          end
          MODE_BLINK: begin
            if (TICK) begin
              if (at_end) begin
                cnt   <= '0;
                led_q <= ~led_q;
              end else begin
                cnt <= cnt + HALF_W'(1);
              end
            end
          end
          default: begin // MODE_BURST
            if (TICK) begin
              if (at_end) begin
                cnt   <= '0;
                hc    <= hc_next;
                led_q <= burst_led;
              end else begin
                cnt <= cnt + HALF_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// ---------------------------------------------------------------------------
// tb_led_blinker_multi
//
// Bench for led_blinker_multi with CHANNELS=4, TICK_DIV=4, HALF_W=4, BURST_N=3.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// updates on the rising edge. Expected LED run lengths (in clock cycles) are
// pushed to exp_q when a channel is configured and popped as runs complete.
// ---------------------------------------------------------------------------
module tb_led_blinker_multi;

  localparam int CH  = 4;
  localparam int TD  = 4;
  localparam int HW  = 4;
  localparam int BN  = 3;
  localparam int BND = 400;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst_n;
  logic              en;
  logic [2*CH-1:0]   mode;
  logic [HW*CH-1:0]  half;
  logic [CH-1:0]     led;
  logic              tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_blinker_multi #(
    .CHANNELS (CH),
    .TICK_DIV (TD),
    .HALF_W   (HW),
    .BURST_N  (BN)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .EN       (en),
    .MODE     (mode),
    .HALF     (half),
    .LED      (led),
    .TICK     (tick)
  );

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic set_half(input int ch, input logic [HW-1:0] h);
    half[HW*ch +: HW] = h;
  endtask

  // Advance until LED[ch] differs from its value now (bounded).
  task automatic wait_change(input int ch, input string name);
    logic v;
    bit   done;
    v    = led[ch];
    done = 1'b0;
    for (int t = 0; t < BND && !done; t++) begin
      cyc();
      if (led[ch] !== v) done = 1'b1;
    end
    if (!done) check({name, " timeout"}, 0, 1);
  endtask

  // Starting on the sample where a new run begins, measure n runs of LED[ch]
  // and compare each against the next queued expectation.
  task automatic measure_runs(input int ch, input int n, input string name);
    logic        v;
    int          cnt;
    bit          done;
    logic [15:0] e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        check({name, " queue empty"}, 0, 1);
        return;
      end
      e    = exp_q.pop_front();
      v    = led[ch];
      cnt  = 1;
      done = 1'b0;
      for (int t = 0; t < BND && !done; t++) begin
        cyc();
        if (led[ch] === v) cnt++;
        else done = 1'b1;
      end
      check(name, cnt, int'(e));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    mode;
    logic [HW-1:0] half;
    int            n;
    int            runs[11];
  } vec_t;

  vec_t tbl[5];

  // Safety net: the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int ticks;
    int hi2;
    int hi3;
    int other_bad;
    bit done;
    logic v;

    total = 0;
    bad   = 0;

    // Steady-state run lengths: BLINK H -> H*TD per half;
    // BURST H=1 -> 4,4,4,4 then dark 28 (= 4 + 2*BN*4).
    tbl[0].mode = M_BLINK; tbl[0].half = 4'd3; tbl[0].n = 4;
    tbl[0].runs = '{12, 12, 12, 12, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].mode = M_BLINK; tbl[1].half = 4'd0; tbl[1].n = 4;
    tbl[1].runs = '{4, 4, 4, 4, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].mode = M_BLINK; tbl[2].half = 4'd2; tbl[2].n = 4;
    tbl[2].runs = '{8, 8, 8, 8, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].mode = M_BURST; tbl[3].half = 4'd1; tbl[3].n = 11;
    tbl[3].runs = '{4, 4, 4, 4, 28, 4, 4, 4, 4, 4, 28};
    tbl[4].mode = M_BURST; tbl[4].half = 4'd2; tbl[4].n = 6;
    tbl[4].runs = '{8, 8, 8, 8, 56, 8, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    en    = 1'b1;
    mode  = '0;
    half  = '0;

    // ---- reset state ----
    repeat (3) cyc();
    check("reset led", int'(led), 0);
    check("reset tick", int'(tick), 0);
    rst_n = 1'b1;

    // ---- tick spacing ----
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      cyc();
      if (tick) done = 1'b1;
    end
    if (!done) check("tick first timeout", 0, 1);
    for (int k = 0; k < 4; k++) begin
      r    = 0;
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
        cyc();
        r++;
        if (tick) done = 1'b1;
      end
      check("tick interval", r, TD);
    end

    // ---- table-driven steady-state patterns on ch0 ----
    for (int i = 0; i < 5; i++) begin
      set_mode(0, M_OFF);
      cyc();
      cyc();
      check("table off", int'(led[0]), 0);
      set_half(0, tbl[i].half);
      set_mode(0, tbl[i].mode);
      for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(16'(tbl[i].runs[k]));
      cyc();
      check("table entry", int'(led[0]), 1);
      wait_change(0, "table first half");
      measure_runs(0, tbl[i].n, "table run");
    end

    // ---- HALF shrink 8 -> 2 with cnt=5 ----
    set_mode(0, M_OFF);
    cyc();
    cyc();
    set_half(0, 4'd8);
    set_mode(0, M_BLINK);
    cyc();
    check("shrink entry", int'(led[0]), 1);
    ticks = 0;
    for (int t = 0; t < 100 && ticks < 5; t++) begin
      if (tick) ticks++;
      if (ticks < 5) cyc();
    end
    cyc();
    check("shrink hold", int'(led[0]), 1);
    set_half(0, 4'd2);
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      if (tick) done = 1'b1;
      else cyc();
    end
    if (!done) check("shrink tick timeout", 0, 1);
    check("shrink pre-boundary", int'(led[0]), 1);
    cyc();
    check("shrink boundary", int'(led[0]), 0);
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd8);
    measure_runs(0, 2, "shrink run");

    // ---- EN freeze mid-half ----
    set_mode(0, M_OFF);
    cyc();
    cyc();
    set_half(0, 4'd3);
    set_mode(0, M_BLINK);
    cyc();
    wait_change(0, "freeze first half");
    v = led[0];
    r = 1;
    repeat (4) begin
      cyc();
      if (led[0] === v) r++;
    end
    en = 1'b0;
    other_bad = 0;
    repeat (10) begin
      cyc();
      if (tick !== 1'b0 || led[0] !== v) other_bad++;
      else r++;
    end
    check("freeze tick/led held", other_bad, 0);
    en = 1'b1;
    done = 1'b0;
    for (int t = 0; t < BND && !done; t++) begin
      cyc();
      if (led[0] === v) r++;
      else done = 1'b1;
    end
    check("freeze run", r, 12 + 10);

    // ---- mid-operation reset ----
    set_mode(1, M_ON);
    repeat (7) cyc();
    rst_n = 1'b0;
    #1;
    check("async reset led", int'(led), 0);
    check("async reset tick", int'(tick), 0);
    mode = '0;
    set_mode(0, M_BLINK);
    repeat (3) cyc();
    check("reset held led", int'(led), 0);
    rst_n = 1'b1;
    cyc();
    check("reset release entry", int'(led), 1);

    // ---- ch1 mode switches ----
    set_mode(0, M_OFF);
    set_half(1, 4'd3);
    set_mode(1, M_BLINK);
    cyc();
    wait_change(1, "switch first half");
    cyc();
    check("switch low", int'(led[1]), 0);
    set_mode(1, M_ON);
    cyc();
    check("blink->on", int'(led[1]), 1);
    cyc();
    set_mode(1, M_BLINK);
    cyc();
    check("on->blink", int'(led[1]), 1);
    r    = 1;
    done = 1'b0;
    for (int t = 0; t < BND && !done; t++) begin
      cyc();
      if (led[1] === 1'b1) r++;
      else done = 1'b1;
    end
    check_range("on->blink first half", r, 2*TD + 1, 3*TD);

    // ---- BURST -> OFF on ch3 ----
    set_mode(1, M_OFF);
    set_half(3, 4'd1);
    set_mode(3, M_BURST);
    cyc();
    check("burst entry", int'(led[3]), 1);
    set_mode(3, M_OFF);
    cyc();
    check("burst->off", int'(led[3]), 0);

    // ---- all four channels at once ----
    set_half(2, 4'd1);
    set_half(3, 4'd1);
    set_mode(0, M_OFF);
    set_mode(1, M_ON);
    set_mode(2, M_BLINK);
    set_mode(3, M_BURST);
    cyc();
    check("multi entry", int'(led), 4'b1110);
    wait_change(2, "multi ch2 first half");
    repeat (4) exp_q.push_back(16'd4);
    measure_runs(2, 4, "multi ch2 run");
    // Over two full burst periods (96 cycles): ch3 lit 24, ch2 lit 48.
    hi2 = 0;
    hi3 = 0;
    other_bad = 0;
    repeat (96) begin
      cyc();
      if (led[2]) hi2++;
      if (led[3]) hi3++;
      if (led[1:0] !== 2'b10) other_bad++;
    end
    check("multi ch2 duty", hi2, 48);
    check("multi ch3 duty", hi3, 24);
    check("multi ch0/ch1 static", other_bad, 0);

    check("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
